// File: rtl/qa_sim_afu_reset_seq.sv
// Reset/health sequencer: staggered per-channel soft-reset release, error latching,
// re-reset requests and per-channel heartbeat watchdogs. All outputs are registered.
module qa_sim_afu_reset_seq #(
  parameter int N_CHAN            = 2,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int STAGGER_CYCLES    = 4,
  parameter int WATCHDOG_CYCLES   = 1024
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              soft_reset_req,
  input  logic              error_in,
  input  logic [1:0]        pwr_state_in,
  input  logic [N_CHAN-1:0] chan_heartbeat,
  output logic [N_CHAN-1:0] chan_soft_reset,
  output logic              all_ready,
  output logic              error_sticky,
  output logic [N_CHAN-1:0] watchdog_expired,
  output logic [15:0]       reset_count,
  output logic [1:0]        seq_state
);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_ERROR   = 2'd3
  } seqState_t;

  localparam int LAST_EDGE = RESET_HOLD_CYCLES + (N_CHAN - 1) * STAGGER_CYCLES;
  localparam int SEQ_W     = $clog2(LAST_EDGE + 1);
  localparam int WD_W      = $clog2(WATCHDOG_CYCLES) + 1;
  localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(WATCHDOG_CYCLES);
  localparam logic [SEQ_W-1:0] HOLD_EDGE = SEQ_W'(RESET_HOLD_CYCLES);
  localparam logic [SEQ_W-1:0] RUN_EDGE  = SEQ_W'(LAST_EDGE);

  seqState_t         state, stateNext;
  logic [SEQ_W-1:0]  seqCnt, seqCntNext, edgeNum;
  logic [N_CHAN-1:0] chanRstNext, wdFlagNext;
  logic [WD_W-1:0]   wdCnt     [N_CHAN];
  logic [WD_W-1:0]   wdCntNext [N_CHAN];
  logic              errSet, errClr, bumpCount, clearWd, runWd;

  always_comb begin
    stateNext   = state;
    seqCntNext  = seqCnt;
    chanRstNext = chan_soft_reset;
    errSet      = 1'b0;
    errClr      = 1'b0;
    bumpCount   = 1'b0;
    clearWd     = 1'b0;
    runWd       = 1'b0;
    // seqCnt holds the number of edges already spent since HOLD was entered
    edgeNum     = seqCnt + SEQ_W'(1);
    case (state)
      ST_HOLD, ST_RELEASE: begin
        if (error_in) begin
          stateNext   = ST_ERROR;
          seqCntNext  = '0;
          chanRstNext = '1;
          errSet      = 1'b1;
        end else if (state == ST_RELEASE && soft_reset_req) begin
          stateNext   = ST_HOLD;
          seqCntNext  = '0;
          chanRstNext = '1;
          clearWd     = 1'b1;
          bumpCount   = 1'b1;
        end else begin
          seqCntNext = edgeNum;
          for (int i = 0; i < N_CHAN; i++) begin
            if (edgeNum == SEQ_W'(RESET_HOLD_CYCLES + i * STAGGER_CYCLES)) chanRstNext[i] = 1'b0;
          end
          // Last-channel check first so a single channel goes HOLD -> RUN directly
          if (edgeNum == RUN_EDGE) begin
            stateNext  = ST_RUN;
            seqCntNext = '0;
          end else if (edgeNum == HOLD_EDGE) begin
            stateNext = ST_RELEASE;
          end
        end
      end
      ST_RUN: begin
        if (error_in) begin
          stateNext   = ST_ERROR;
          chanRstNext = '1;
          errSet      = 1'b1;
        end else if (soft_reset_req) begin
          stateNext   = ST_HOLD;
          seqCntNext  = '0;
          chanRstNext = '1;
          clearWd     = 1'b1;
          bumpCount   = 1'b1;
        end else begin
          runWd = 1'b1;
        end
      end
      default: begin
        // ERROR: an error_in seen together with the request is re-sampled from HOLD
        if (soft_reset_req) begin
          stateNext  = ST_HOLD;
          seqCntNext = '0;
          errClr     = 1'b1;
          clearWd    = 1'b1;
          bumpCount  = 1'b1;
        end
      end
    endcase

    for (int i = 0; i < N_CHAN; i++) begin
      wdCntNext[i]  = wdCnt[i];
      wdFlagNext[i] = watchdog_expired[i];
      if (clearWd) begin
        wdCntNext[i]  = '0;
        wdFlagNext[i] = 1'b0;
      end else if (runWd) begin
        if (chan_heartbeat[i]) begin
          wdCntNext[i] = '0;
        end else if (pwr_state_in == 2'd0 && wdCnt[i] != WD_LIMIT) begin
          wdCntNext[i] = wdCnt[i] + WD_W'(1);
        end
        if (wdCntNext[i] == WD_LIMIT) wdFlagNext[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state            <= ST_HOLD;
      seqCnt           <= '0;
      chan_soft_reset  <= '1;
      all_ready        <= 1'b0;
      error_sticky     <= 1'b0;
      watchdog_expired <= '0;
      reset_count      <= '0;
      for (int i = 0; i < N_CHAN; i++) wdCnt[i] <= '0;
    end else begin
      state            <= stateNext;
      seqCnt           <= seqCntNext;
      chan_soft_reset  <= chanRstNext;
      all_ready        <= (stateNext == ST_RUN);
      watchdog_expired <= wdFlagNext;
      for (int i = 0; i < N_CHAN; i++) wdCnt[i] <= wdCntNext[i];
      if (errSet)      error_sticky <= 1'b1;
      else if (errClr) error_sticky <= 1'b0;
      if (bumpCount && reset_count != 16'hFFFF) reset_count <= reset_count + 16'd1;
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_qa_sim_afu_reset_seq.sv
// Bench for qa_sim_afu_reset_seq: a directed driver schedules hand-computed expectations
// per clock edge into a queue; a monitor pops them and compares on the falling edge.
module tb_qa_sim_afu_reset_seq;

  localparam int QW = 44;  // {cycle[23:0], select[3:0], value[15:0]}

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       softReq, errIn, hb0, hb1;
  logic [1:0] pwr;

  logic [1:0]  aChanRst, aWd, aSeq;
  logic        aAllReady, aErr;
  logic [15:0] aRc;

  logic [3:0]  bHb = 4'hF;
  logic        bSoft = 1'b0, bErrIn = 1'b0;
  logic [1:0]  bPwr = 2'd0;
  logic [3:0]  bChanRst, bWd;
  logic        bAllReady, bErr;
  logic [15:0] bRc;
  logic [1:0]  bSeq;

  int cycleNum = 0;
  int nChecks  = 0;
  int nErrors  = 0;
  logic finalFlush = 1'b0;
  logic [QW-1:0] exp_q[$];

  qa_sim_afu_reset_seq #(
    .N_CHAN(2), .RESET_HOLD_CYCLES(16), .STAGGER_CYCLES(4), .WATCHDOG_CYCLES(8)
  ) dutA (
    .CLK(CLK), .RST_N(RST_N), .soft_reset_req(softReq), .error_in(errIn),
    .pwr_state_in(pwr), .chan_heartbeat({hb1, hb0}), .chan_soft_reset(aChanRst),
    .all_ready(aAllReady), .error_sticky(aErr), .watchdog_expired(aWd),
    .reset_count(aRc), .seq_state(aSeq)
  );

  qa_sim_afu_reset_seq #(
    .N_CHAN(4), .RESET_HOLD_CYCLES(3), .STAGGER_CYCLES(1), .WATCHDOG_CYCLES(8)
  ) dutB (
    .CLK(CLK), .RST_N(RST_N), .soft_reset_req(bSoft), .error_in(bErrIn),
    .pwr_state_in(bPwr), .chan_heartbeat(bHb), .chan_soft_reset(bChanRst),
    .all_ready(bAllReady), .error_sticky(bErr), .watchdog_expired(bWd),
    .reset_count(bRc), .seq_state(bSeq)
  );

  // clock / reset block
  always #5 CLK = ~CLK;
  always @(posedge CLK) cycleNum <= cycleNum + 1;

  // channel 0 of dutA heartbeats every 4 cycles; channel 1 never does
  initial begin
    hb0 = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      hb0 = ((cycleNum % 4) == 3);
    end
  end

  function automatic string selName(input int sel);
    case (sel)
      0: return "a_chan_soft_reset";
      1: return "a_all_ready";
      2: return "a_seq_state";
      3: return "a_error_sticky";
      4: return "a_watchdog_expired";
      5: return "a_reset_count";
      6: return "b_chan_soft_reset";
      7: return "b_seq_state";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [15:0] actualOf(input int sel);
    case (sel)
      0: return {14'd0, aChanRst};
      1: return {15'd0, aAllReady};
      2: return {14'd0, aSeq};
      3: return {15'd0, aErr};
      4: return {14'd0, aWd};
      5: return aRc;
      6: return {12'd0, bChanRst};
      7: return {14'd0, bSeq};
      default: return 16'd0;
    endcase
  endfunction

  // driver tasks
  task automatic waitEdges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic expectAt(input int cyc, input int sel, input logic [15:0] val);
    logic [QW-1:0] item;
    logic [3:0]    selBits;
    int            pos;
    selBits = sel[3:0];
    item = {cyc[23:0], selBits, val};
    pos = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (int'(exp_q[i][43:20]) > cyc) begin
        pos = i;
        break;
      end
    end
    exp_q.insert(pos, item);
  endtask

  task automatic expectResetA(input int cyc);
    expectAt(cyc, 0, 16'h3);
    expectAt(cyc, 1, 16'h0);
    expectAt(cyc, 2, 16'h0);
    expectAt(cyc, 3, 16'h0);
    expectAt(cyc, 4, 16'h0);
    expectAt(cyc, 5, 16'h0);
  endtask

  // scoreboard monitor
  initial begin
    logic [QW-1:0] item;
    int            cyc, sel;
    logic [15:0]   got;
    forever begin
      @(negedge CLK);
      while (exp_q.size() > 0 && (finalFlush || int'(exp_q[0][43:20]) <= cycleNum)) begin
        item = exp_q.pop_front();
        cyc  = int'(item[43:20]);
        sel  = int'(item[19:16]);
        got  = actualOf(sel);
        nChecks++;
        if (cyc != cycleNum) begin
          nErrors++;
          $display("FAIL %s at edge %0d: check not reached in time (now edge %0d)", selName(sel), cyc, cycleNum);
        end else if (got !== item[15:0]) begin
          nErrors++;
          $display("FAIL %s at edge %0d: got 0x%0h, want 0x%0h", selName(sel), cyc, got, item[15:0]);
        end
      end
    end
  end

  initial begin
    int s, t, v, w, x;
    RST_N = 1'b0; softReq = 1'b0; errIn = 1'b0; pwr = 2'd0; hb1 = 1'b0;

    // reset values
    expectResetA(2);
    expectAt(2, 6, 16'hF);
    expectAt(2, 7, 16'h0);
    waitEdges(3);

    // staggered release for both geometries
    s = cycleNum;
    RST_N = 1'b1;
    expectAt(s + 1, 0, 16'h3);
    expectAt(s + 15, 0, 16'h3);
    expectAt(s + 15, 2, 16'h0);
    expectAt(s + 16, 0, 16'h2);
    expectAt(s + 16, 1, 16'h0);
    expectAt(s + 16, 2, 16'h1);
    expectAt(s + 19, 0, 16'h2);
    expectAt(s + 20, 0, 16'h0);
    expectAt(s + 20, 1, 16'h1);
    expectAt(s + 20, 2, 16'h2);
    expectAt(s + 2, 6, 16'hF);
    expectAt(s + 2, 7, 16'h0);
    expectAt(s + 3, 6, 16'hE);
    expectAt(s + 3, 7, 16'h1);
    expectAt(s + 4, 6, 16'hC);
    expectAt(s + 5, 6, 16'h8);
    expectAt(s + 5, 7, 16'h1);
    expectAt(s + 6, 6, 16'h0);
    expectAt(s + 6, 7, 16'h2);
    // channel 1 idle from the first RUN edge: flag after 8 counting edges
    expectAt(s + 27, 4, 16'h0);
    expectAt(s + 28, 4, 16'h2);
    waitEdges(30);

    // soft reset from RUN, repeat sequence, low-power delays the watchdog by 5
    t = cycleNum + 1;
    expectAt(t, 0, 16'h3);
    expectAt(t, 1, 16'h0);
    expectAt(t, 2, 16'h0);
    expectAt(t, 4, 16'h0);
    expectAt(t, 5, 16'h1);
    expectAt(t + 15, 0, 16'h3);
    expectAt(t + 16, 0, 16'h2);
    expectAt(t + 16, 2, 16'h1);
    expectAt(t + 20, 0, 16'h0);
    expectAt(t + 20, 1, 16'h1);
    expectAt(t + 20, 2, 16'h2);
    expectAt(t + 20, 5, 16'h1);
    expectAt(t + 32, 4, 16'h0);
    expectAt(t + 33, 4, 16'h2);
    softReq = 1'b1;
    waitEdges(1);
    softReq = 1'b0;
    waitEdges(20);
    pwr = 2'b01;
    waitEdges(5);
    pwr = 2'b00;
    waitEdges(10);

    // soft reset, then an error pulse in the middle of RELEASE
    v = cycleNum + 1;
    expectAt(v, 0, 16'h3);
    expectAt(v, 2, 16'h0);
    expectAt(v, 4, 16'h0);
    expectAt(v, 5, 16'h2);
    expectAt(v + 16, 0, 16'h2);
    expectAt(v + 16, 2, 16'h1);
    expectAt(v + 18, 0, 16'h3);
    expectAt(v + 18, 1, 16'h0);
    expectAt(v + 18, 2, 16'h3);
    expectAt(v + 18, 3, 16'h1);
    expectAt(v + 118, 0, 16'h3);
    expectAt(v + 118, 2, 16'h3);
    expectAt(v + 118, 3, 16'h1);
    expectAt(v + 118, 5, 16'h2);
    expectAt(v + 119, 0, 16'h3);
    expectAt(v + 119, 2, 16'h0);
    expectAt(v + 119, 3, 16'h0);
    expectAt(v + 119, 5, 16'h3);
    softReq = 1'b1;
    waitEdges(1);
    softReq = 1'b0;
    waitEdges(17);
    errIn = 1'b1;
    waitEdges(1);
    errIn = 1'b0;
    waitEdges(100);
    softReq = 1'b1;
    waitEdges(1);
    softReq = 1'b0;

    // simultaneous error/soft-reset in RUN, then in ERROR, then error re-sampled in HOLD
    w = cycleNum;
    expectAt(w + 20, 1, 16'h1);
    expectAt(w + 20, 2, 16'h2);
    expectAt(w + 22, 1, 16'h0);
    expectAt(w + 22, 2, 16'h3);
    expectAt(w + 22, 3, 16'h1);
    expectAt(w + 22, 5, 16'h3);
    expectAt(w + 24, 2, 16'h0);
    expectAt(w + 24, 3, 16'h0);
    expectAt(w + 24, 5, 16'h4);
    expectAt(w + 25, 2, 16'h3);
    expectAt(w + 25, 3, 16'h1);
    expectAt(w + 25, 5, 16'h4);
    waitEdges(21);
    errIn = 1'b1; softReq = 1'b1;
    waitEdges(1);
    errIn = 1'b0; softReq = 1'b0;
    waitEdges(1);
    errIn = 1'b1; softReq = 1'b1;
    waitEdges(1);
    softReq = 1'b0;
    waitEdges(1);
    errIn = 1'b0;
    waitEdges(1);

    // leave ERROR; a request in HOLD is ignored; watchdog fires; 1-cycle reset mid-RUN
    x = cycleNum + 1;
    expectAt(x, 2, 16'h0);
    expectAt(x, 3, 16'h0);
    expectAt(x, 5, 16'h5);
    expectAt(x + 5, 0, 16'h3);
    expectAt(x + 5, 2, 16'h0);
    expectAt(x + 5, 5, 16'h5);
    expectAt(x + 16, 2, 16'h1);
    expectAt(x + 20, 0, 16'h0);
    expectAt(x + 20, 2, 16'h2);
    expectAt(x + 28, 4, 16'h2);
    expectAt(x + 29, 5, 16'h5);
    expectAt(x + 29, 1, 16'h1);
    expectResetA(x + 30);
    softReq = 1'b1;
    waitEdges(1);
    softReq = 1'b0;
    waitEdges(4);
    softReq = 1'b1;
    waitEdges(1);
    softReq = 1'b0;
    waitEdges(24);
    RST_N = 1'b0;
    waitEdges(1);
    RST_N = 1'b1;

    // drain with a bound; anything left is reported by the monitor as unreached
    for (int k = 0; k < 50 && exp_q.size() > 0; k++) waitEdges(1);
    finalFlush = 1'b1;
    waitEdges(2);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/qa_sim_afu_reset_seq.md
Name: qa_sim_afu_reset_seq

Overview:
Parametrised reset/health sequencer for the QuickAssist simulation top level. It is driven by the single simulation clock and reset. It replaces the single CCI-P soft-reset wire with N_CHAN per-AFU-channel soft resets that are released in a staggered order. It also adds error latching, re-reset requests, and per-channel heartbeat watchdogs that stall-free simulations can check.

Parameters:
N_CHAN, 2, number of AFU channels driven (>=1)
RESET_HOLD_CYCLES, 16, cycles all resets stay asserted in HOLD (>=1)
STAGGER_CYCLES, 4, cycles between successive channel releases (>=1)
WATCHDOG_CYCLES, 1024, heartbeat-free RUN cycles before a channel is flagged (>=2)

Ports:
CLK  in  1  simulation clock; all logic on rising edge
RST_N  in  1  reset, synchronous, active-low
soft_reset_req  in  1  single-cycle request to re-run the reset sequence
error_in  in  1  CCI-P protocol error from emulator
pwr_state_in  in  2  CCI-P power state; nonzero freezes watchdogs
chan_heartbeat  in  N_CHAN  per-channel liveness pulse
chan_soft_reset  out  N_CHAN  per-channel soft reset, active-high
all_ready  out  1  high only in RUN
error_sticky  out  1  latched protocol error
watchdog_expired  out  N_CHAN  sticky per-channel watchdog flags
reset_count  out  16  number of completed re-reset requests, saturating at 0xFFFF
seq_state  out  2  FSM state: 0 HOLD, 1 RELEASE, 2 RUN, 3 ERROR

Behaviour:
- RST_N=0 at an edge: state HOLD; chan_soft_reset all 1; all_ready 0; error_sticky 0; watchdog_expired 0; reset_count 0; all counters 0. Reset mid-sequence behaves identically.
- Edge numbering: edge 1 is the first edge sampling RST_N=1, or the first edge after HOLD is re-entered.
- HOLD: all resets stay asserted. After edge RESET_HOLD_CYCLES the FSM moves to RELEASE and chan_soft_reset[0] goes to 0 at that same edge.
- RELEASE: chan_soft_reset[i] goes to 0 after edge RESET_HOLD_CYCLES + i*STAGGER_CYCLES, in ascending index order. Once released, a channel stays released until HOLD or ERROR.
  - At the edge that releases channel N_CHAN-1, the FSM enters RUN and all_ready goes to 1 at that same edge.
  - With N_CHAN=1, HOLD goes directly to RUN.
- RUN:
  - Each channel has a watchdog counter, clog2(WATCHDOG_CYCLES)+1 bits wide.
  - chan_heartbeat[i]=1 clears counter i to 0.
  - Otherwise, if pwr_state_in==0, counter i increments and saturates.
  - If pwr_state_in!=0, counter i holds.
  - When counter i reaches WATCHDOG_CYCLES, watchdog_expired[i] is set and stays set. The FSM does not leave RUN.
- soft_reset_req=1 in RELEASE or RUN: next state HOLD.
  - All resets reassert at that edge; all_ready 0.
  - Watchdog counters and flags clear.
  - reset_count increments, saturating.
  - soft_reset_req in HOLD is ignored and does not increment reset_count.
- error_in=1 in any non-ERROR state: next state ERROR.
  - All resets assert; error_sticky 1; all_ready 0; watchdogs freeze.
  - ERROR is held until soft_reset_req=1, which moves to HOLD, clears error_sticky, and increments reset_count.
- Simultaneous events:
  - error_in together with soft_reset_req in a non-ERROR state: ERROR wins and reset_count is unchanged.
  - error_in together with soft_reset_req in ERROR: go to HOLD, then error_in is sampled again from HOLD.
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- N_CHAN=2, HOLD=16, STAGGER=4, RST_N raised -> chan_soft_reset 2'b11 through edge 15, 2'b10 after edge 16, 2'b00 plus all_ready=1 plus seq_state=2 after edge 20.
- N_CHAN=4, HOLD=3, STAGGER=1 -> channels released after edges 3, 4, 5, 6 respectively; seq_state passes 0, 1, 2.
- RUN, WATCHDOG=8, chan_heartbeat=0 for channel 1, heartbeat every 4 cycles on channel 0 -> watchdog_expired=2'b10 after 8 idle edges. With pwr_state_in=2'b01 driven for the first 5 of those cycles, the flag is instead delayed by exactly 5 edges.
- RUN, pulse soft_reset_req -> chan_soft_reset=all ones and reset_count=1 at the next edge; the release sequence repeats with the same timing; the watchdog flag is cleared.
- Mid-RELEASE error_in pulse -> seq_state=3, error_sticky=1, all resets asserted, held for 100 cycles. Then soft_reset_req -> HOLD, error_sticky=0, reset_count=1.
- Same-cycle error_in and soft_reset_req in RUN -> ERROR, reset_count unchanged. RST_N low for 1 cycle mid-RUN -> every output returns to its reset value.
